// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse packet decoder.
//   - state_t   : packet assembly FSM states
//   - BTN_L..YO : bit positions inside the first (header) byte of a packet
//   - hdr_t     : header fields kept between the first and third byte
//   - default timeout and screen geometry
package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    localparam int TIMEOUT_DEF = 200_000;
    localparam int X_MAX_DEF   = 639;
    localparam int Y_MAX_DEF   = 479;
    localparam int X_INIT_DEF  = 320;
    localparam int Y_INIT_DEF  = 240;

    // The SYNC bit is always 1 for an accepted header, so it is not stored.
    typedef struct packed {
        logic yo;
        logic xo;
        logic ys;
        logic xs;
        logic bm;
        logic br;
        logic bl;
    } hdr_t;

    function automatic hdr_t hdr_from_byte(input logic [7:0] b);
        hdr_t h;
        h.yo = b[YO];
        h.xo = b[XO];
        h.ys = b[YS];
        h.xs = b[XS];
        h.bm = b[BTN_M];
        h.br = b[BTN_R];
        h.bl = b[BTN_L];
        return h;
    endfunction

endpackage

// File: rtl/ps2_axis_clamp.sv
// Combinational next-position calculation for one cursor axis.
//   pos      : current position, 0..max
//   delta    : 9-bit two's-complement movement
//   neg      : 1 = subtract delta (screen Y grows downwards, mouse Y grows upwards)
//   ovf      : 1 = movement overflowed; position is left unchanged
//   max      : largest legal position
//   next_pos : position after movement, clamped to 0..max
module ps2_axis_clamp
    import ps2_pkg::*;
(
    input  logic [9:0] pos,
    input  logic [8:0] delta,
    input  logic       neg,
    input  logic       ovf,
    input  logic [9:0] max,
    output logic [9:0] next_pos
);

    // 12 bits covers -256 .. 1023+255 without wrapping.
    function automatic logic [9:0] sat_pos(input logic signed [11:0] v,
                                           input logic [9:0]         hi);
        if (v < 12'sd0)
            return 10'd0;
        else if (v > $signed({2'b00, hi}))
            return hi;
        else
            return v[9:0];
    endfunction

    logic signed [11:0] pos_s;
    logic signed [11:0] step_s;
    logic signed [11:0] sum_s;

    always_comb begin
        pos_s    = $signed({2'b00, pos});
        step_s   = ovf ? 12'sd0 : $signed({{3{delta[8]}}, delta});
        sum_s    = neg ? (pos_s - step_s) : (pos_s + step_s);
        next_pos = sat_pos(sum_s, max);
    end

endmodule

// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler.
// Collects the 3-byte packets delivered by the PS/2 receiver, resynchronises on
// a header byte without its sync bit or on an inter-byte timeout, and publishes
// the decoded buttons, deltas and overflow flags together with a clamped cursor.
//   clk, reset          : clock, asynchronous active-high reset
//   rx_done, rx_data    : one-cycle byte strobe and its byte
//   pkt_valid           : one-cycle strobe, new packet on btn_*/dx/dy/ovf_*
//   btn_left/right/mid  : button states from the header byte
//   dx, dy              : 9-bit signed movement (dy positive = up)
//   ovf_x, ovf_y        : movement overflow flags
//   cursor_x, cursor_y  : clamped cursor position (0,0 = top-left)
//   sync_err            : one-cycle strobe, byte dropped or packet aborted
module ps2_mouse_packet
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEF,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int Y_MAX       = Y_MAX_DEF,
    parameter int X_INIT      = X_INIT_DEF,
    parameter int Y_INIT      = Y_INIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              pkt_valid,
    output logic              btn_left,
    output logic              btn_right,
    output logic              btn_mid,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic              ovf_x,
    output logic              ovf_y,
    output logic [9:0]        cursor_x,
    output logic [9:0]        cursor_y,
    output logic              sync_err
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    hdr_t             hdr_q;
    logic [7:0]       byte1_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             take_b0;
    logic             take_b1;
    logic             drop_byte;
    logic             pkt_done;
    logic             timeout;

    logic [8:0]       dx_new;
    logic [8:0]       dy_new;
    logic [9:0]       cursor_x_new;
    logic [9:0]       cursor_y_new;

    // A byte arriving in the timeout cycle takes priority over the timeout.
    assign timeout = (state_q != WAIT_B0) && !rx_done && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        take_b0   = 1'b0;
        take_b1   = 1'b0;
        drop_byte = 1'b0;
        pkt_done  = 1'b0;

        if (state_q == WAIT_B0 || rx_done)
            cnt_d = '0;
        else if (cnt_q != CNT_LAST)
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;

        unique case (state_q)
            WAIT_B0: begin
                if (rx_done) begin
                    if (rx_data[SYNC]) begin
                        take_b0 = 1'b1;
                        state_d = WAIT_B1;
                    end else begin
                        drop_byte = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (rx_done) begin
                    take_b1 = 1'b1;
                    state_d = WAIT_B2;
                end else if (timeout) begin
                    state_d = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (rx_done) begin
                    pkt_done = 1'b1;
                    state_d  = WAIT_B0;
                end else if (timeout) begin
                    state_d = WAIT_B0;
                end
            end
            default: state_d = WAIT_B0;
        endcase
    end

    // The third byte is used straight from rx_data so the packet and the
    // cursor land on the same edge.
    assign dx_new = {hdr_q.xs, byte1_q};
    assign dy_new = {hdr_q.ys, rx_data};

    ps2_axis_clamp u_clamp_x (
        .pos      (cursor_x),
        .delta    (dx_new),
        .neg      (1'b0),
        .ovf      (hdr_q.xo),
        .max      (10'(X_MAX)),
        .next_pos (cursor_x_new)
    );

    ps2_axis_clamp u_clamp_y (
        .pos      (cursor_y),
        .delta    (dy_new),
        .neg      (1'b1),
        .ovf      (hdr_q.yo),
        .max      (10'(Y_MAX)),
        .next_pos (cursor_y_new)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_B0;
            cnt_q     <= '0;
            hdr_q     <= '0;
            byte1_q   <= '0;
            pkt_valid <= 1'b0;
            sync_err  <= 1'b0;
            btn_left  <= 1'b0;
            btn_right <= 1'b0;
            btn_mid   <= 1'b0;
            dx        <= '0;
            dy        <= '0;
            ovf_x     <= 1'b0;
            ovf_y     <= 1'b0;
            cursor_x  <= 10'(X_INIT);
            cursor_y  <= 10'(Y_INIT);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pkt_valid <= pkt_done;
            sync_err  <= drop_byte | timeout;
            if (take_b0)
                hdr_q <= hdr_from_byte(rx_data);
            if (take_b1)
                byte1_q <= rx_data;
            if (pkt_done) begin
                btn_left  <= hdr_q.bl;
                btn_right <= hdr_q.br;
                btn_mid   <= hdr_q.bm;
                dx        <= $signed(dx_new);
                dy        <= $signed(dy_new);
                ovf_x     <= hdr_q.xo;
                ovf_y     <= hdr_q.yo;
                cursor_x  <= cursor_x_new;
                cursor_y  <= cursor_y_new;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
module tb_ps2_mouse_packet;

    localparam int T     = 40;
    localparam int XMAX  = 639;
    localparam int YMAX  = 479;
    localparam int XINIT = 320;
    localparam int YINIT = 240;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_done = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              pkt_valid;
    logic              btn_left, btn_right, btn_mid;
    logic signed [8:0] dx, dy;
    logic              ovf_x, ovf_y;
    logic [9:0]        cursor_x, cursor_y;
    logic              sync_err;

    ps2_mouse_packet #(
        .TIMEOUT_CYC (T),
        .X_MAX       (XMAX),
        .Y_MAX       (YMAX),
        .X_INIT      (XINIT),
        .Y_INIT      (YINIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .pkt_valid (pkt_valid),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_mid   (btn_mid),
        .dx        (dx),
        .dy        (dy),
        .ovf_x     (ovf_x),
        .ovf_y     (ovf_y),
        .cursor_x  (cursor_x),
        .cursor_y  (cursor_y),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: packet = header with sync bit, then two bytes; a partial
    // packet survives at most T-1 idle cycles between bytes.
    int         m_have;
    logic [7:0] m_b0, m_b1;
    int         m_idle;
    logic       m_bl, m_br, m_bm, m_ox, m_oy;
    int         m_dx, m_dy, m_cx, m_cy;
    int         exp_pkt = 0, exp_err = 0;
    int         obs_pkt = 0, obs_err = 0;

    logic [42:0] obs_vec;
    assign obs_vec = {btn_mid, btn_right, btn_left, ovf_y, ovf_x, dx, dy, cursor_x, cursor_y};

    function automatic logic [42:0] model_vec();
        return {m_bm, m_br, m_bl, m_oy, m_ox, 9'(m_dx), 9'(m_dy), 10'(m_cx), 10'(m_cy)};
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int sext9(input logic s, input logic [7:0] b);
        return s ? int'(b) - 256 : int'(b);
    endfunction

    task automatic model_reset();
        m_have = 0; m_idle = 0; m_b0 = 0; m_b1 = 0;
        m_bl = 0; m_br = 0; m_bm = 0; m_ox = 0; m_oy = 0;
        m_dx = 0; m_dy = 0; m_cx = XINIT; m_cy = YINIT;
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_idle = 0;
        if (m_have == 0) begin
            if (!b[3]) exp_err++;
            else begin m_b0 = b; m_have = 1; end
        end else if (m_have == 1) begin
            m_b1 = b; m_have = 2;
        end else begin
            m_bl = m_b0[0]; m_br = m_b0[1]; m_bm = m_b0[2];
            m_ox = m_b0[6]; m_oy = m_b0[7];
            m_dx = sext9(m_b0[4], m_b1);
            m_dy = sext9(m_b0[5], b);
            if (!m_ox) m_cx = clampi(m_cx + m_dx, XMAX);
            if (!m_oy) m_cy = clampi(m_cy - m_dy, YMAX);
            exp_pkt++;
            m_have = 0;
        end
    endtask

    task automatic model_idle();
        m_idle++;
        if (m_have != 0 && m_idle == T) begin
            exp_err++;
            m_have = 0;
        end
    endtask

    // Drivers: inputs change 1 time unit after the rising edge; outputs are
    // sampled at the same point, well away from the next edge.
    task automatic send_byte(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_data = 8'($urandom);
        obs_pkt += int'(pkt_valid);
        obs_err += int'(sync_err);
        model_byte(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            obs_pkt += int'(pkt_valid);
            obs_err += int'(sync_err);
            model_idle();
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (obs_vec !== model_vec()) begin
            n_fail++; $display("FAIL reset_outputs got %h expected %h", obs_vec, model_vec());
        end
        n_chk++;
        if ({pkt_valid, sync_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_strobes got %b expected 00", {pkt_valid, sync_err});
        end
        n_chk++;
        if (cursor_x !== 10'd320 || cursor_y !== 10'd240) begin
            n_fail++; $display("FAIL reset_cursor got (%0d,%0d) expected (320,240)", cursor_x, cursor_y);
        end
    endtask

    task automatic test_basic();
        int p0;
        do_reset();
        p0 = obs_pkt;
        send_byte(8'h29); idle(3);
        send_byte(8'h05); idle(3);
        send_byte(8'hFA);
        n_chk++;
        if (obs_pkt - p0 !== 1 || !pkt_valid) begin
            n_fail++; $display("FAIL basic_pkt_valid got %0d pulses expected 1", obs_pkt - p0);
        end
        n_chk++;
        if (dx !== 9'sd5 || dy !== -9'sd6 || btn_left !== 1'b1) begin
            n_fail++; $display("FAIL basic_decode got dx=%0d dy=%0d bl=%b expected dx=5 dy=-6 bl=1", dx, dy, btn_left);
        end
        n_chk++;
        if (cursor_x !== 10'd325 || cursor_y !== 10'd246) begin
            n_fail++; $display("FAIL basic_cursor got (%0d,%0d) expected (325,246)", cursor_x, cursor_y);
        end
        idle(4);
        n_chk++;
        if (obs_vec !== model_vec() || obs_pkt !== exp_pkt || obs_err !== exp_err) begin
            n_fail++; $display("FAIL basic_hold got %h/%0d/%0d expected %h/%0d/%0d", obs_vec, obs_pkt, obs_err, model_vec(), exp_pkt, exp_err);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        send_byte(8'h18); send_byte(8'h80); send_byte(8'h00);
        n_chk++;
        if (dx !== -9'sd128 || cursor_x !== 10'd192) begin
            n_fail++; $display("FAIL clamp_first got dx=%0d x=%0d expected dx=-128 x=192", dx, cursor_x);
        end
        repeat (3) begin
            send_byte(8'h18); idle(1); send_byte(8'h80); send_byte(8'h00);
        end
        n_chk++;
        if (cursor_x !== 10'd0 || obs_vec !== model_vec()) begin
            n_fail++; $display("FAIL clamp_low got x=%0d expected 0", cursor_x);
        end
        repeat (7) begin
            send_byte(8'h08); send_byte(8'h7F); send_byte(8'h00);
        end
        n_chk++;
        if (cursor_x !== 10'd639 || obs_vec !== model_vec()) begin
            n_fail++; $display("FAIL clamp_high got x=%0d expected 639", cursor_x);
        end
    endtask

    task automatic test_stray();
        int e0, p0;
        do_reset();
        e0 = obs_err; p0 = obs_pkt;
        send_byte(8'h05);
        n_chk++;
        if (sync_err !== 1'b1) begin
            n_fail++; $display("FAIL stray_sync_err got %b expected 1", sync_err);
        end
        idle(2);
        send_byte(8'h08); send_byte(8'h01); send_byte(8'h01);
        n_chk++;
        if (obs_err - e0 !== 1 || obs_pkt - p0 !== 1) begin
            n_fail++; $display("FAIL stray_counts got err=%0d pkt=%0d expected err=1 pkt=1", obs_err - e0, obs_pkt - p0);
        end
        n_chk++;
        if (dx !== 9'sd1 || dy !== 9'sd1 || cursor_x !== 10'd321 || cursor_y !== 10'd239) begin
            n_fail++; $display("FAIL stray_decode got dx=%0d dy=%0d (%0d,%0d) expected 1 1 (321,239)", dx, dy, cursor_x, cursor_y);
        end
    endtask

    task automatic test_timeout();
        int e0, p0;
        do_reset();
        e0 = obs_err; p0 = obs_pkt;
        send_byte(8'h08); send_byte(8'h10);
        idle(T - 1);
        n_chk++;
        if (obs_err - e0 !== 0) begin
            n_fail++; $display("FAIL timeout_early got %0d sync_err expected 0", obs_err - e0);
        end
        idle(1);
        n_chk++;
        if (sync_err !== 1'b1 || obs_err - e0 !== 1) begin
            n_fail++; $display("FAIL timeout_pulse got %b/%0d expected 1/1", sync_err, obs_err - e0);
        end
        idle(5);
        send_byte(8'h08); send_byte(8'h02); send_byte(8'h00);
        n_chk++;
        if (obs_pkt - p0 !== 1 || dx !== 9'sd2 || obs_err - e0 !== 1) begin
            n_fail++; $display("FAIL timeout_recover got pkt=%0d dx=%0d err=%0d expected 1 2 1", obs_pkt - p0, dx, obs_err - e0);
        end
        // Byte on the last allowed cycle wins over the timeout.
        send_byte(8'h09); idle(T - 1); send_byte(8'h03); idle(T - 1); send_byte(8'h04);
        n_chk++;
        if (obs_pkt - p0 !== 2 || obs_err - e0 !== 1 || dx !== 9'sd3) begin
            n_fail++; $display("FAIL timeout_boundary got pkt=%0d err=%0d dx=%0d expected 2 1 3", obs_pkt - p0, obs_err - e0, dx);
        end
    endtask

    task automatic test_ovf();
        do_reset();
        send_byte(8'h48); send_byte(8'h7F); send_byte(8'h00);
        n_chk++;
        if (dx !== 9'sd127 || ovf_x !== 1'b1 || cursor_x !== 10'd320) begin
            n_fail++; $display("FAIL ovf_x got dx=%0d ovf=%b x=%0d expected 127 1 320", dx, ovf_x, cursor_x);
        end
        send_byte(8'hA8); send_byte(8'h00); send_byte(8'h80);
        n_chk++;
        if (obs_vec !== model_vec() || ovf_y !== 1'b1 || cursor_y !== 10'd240) begin
            n_fail++; $display("FAIL ovf_y got %h expected %h", obs_vec, model_vec());
        end
    endtask

    task automatic test_reset_midpacket();
        int e0, p0;
        do_reset();
        send_byte(8'h29); send_byte(8'h05); send_byte(8'hFA);
        send_byte(8'h08); send_byte(8'h10);
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_chk++;
        if (obs_vec !== model_vec()) begin
            n_fail++; $display("FAIL midreset_async got %h expected %h", obs_vec, model_vec());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        e0 = obs_err; p0 = obs_pkt;
        send_byte(8'h09); send_byte(8'h05); send_byte(8'hFA);
        idle(2);
        n_chk++;
        if (obs_err - e0 !== 0 || obs_pkt - p0 !== 1 || obs_vec !== model_vec()) begin
            n_fail++; $display("FAIL midreset_next got err=%0d pkt=%0d vec=%h expected 0 1 %h", obs_err - e0, obs_pkt - p0, obs_vec, model_vec());
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int r, g;
        do_reset();
        for (int i = 0; i < 240; i++) begin
            b = 8'($urandom);
            if (m_have == 0 && $urandom_range(0, 99) < 85) b[3] = 1'b1;
            send_byte(b);
            n_chk++;
            if (obs_vec !== model_vec() || obs_pkt !== exp_pkt || obs_err !== exp_err) begin
                n_fail++; $display("FAIL random_byte%0d got %h/%0d/%0d expected %h/%0d/%0d", i, obs_vec, obs_pkt, obs_err, model_vec(), exp_pkt, exp_err);
            end
            r = $urandom_range(0, 19);
            if (r < 16) g = $urandom_range(0, 3);
            else if (r < 18) g = T - 2 + $urandom_range(0, 2);
            else g = T + $urandom_range(0, 3);
            idle(g);
            n_chk++;
            if (obs_pkt !== exp_pkt || obs_err !== exp_err) begin
                n_fail++; $display("FAIL random_gap%0d got pkt=%0d err=%0d expected %0d %0d", i, obs_pkt, obs_err, exp_pkt, exp_err);
            end
        end
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        #12;
        test_reset();
        test_basic();
        test_clamp();
        test_stray();
        test_timeout();
        test_ovf();
        test_reset_midpacket();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
